// File: rtl/spi_slave.sv
// SPI mode-0 responder: samples mosi on sclk rise, shifts miso after sclk fall,
// one-entry tx buffer with ready/load handshake and per-byte rx strobe.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cs_n,
    input  logic              i_sclk,
    input  logic              i_mosi,
    output logic              o_miso,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_load,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_tx_underrun,
    output logic              o_busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic w_sclk, w_mosi, w_cs_n;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_sclk = i_sclk;
            assign w_mosi = i_mosi;
            assign w_cs_n = i_cs_n;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
            // cs_n chain resets deselected so a reset release never fakes a frame start
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sclk_sync <= '0;
                    r_mosi_sync <= '0;
                    r_cs_sync   <= '1;
                end else begin
                    r_sclk_sync[0] <= i_sclk;
                    r_mosi_sync[0] <= i_mosi;
                    r_cs_sync[0]   <= i_cs_n;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sclk_sync[k] <= r_sclk_sync[k-1];
                        r_mosi_sync[k] <= r_mosi_sync[k-1];
                        r_cs_sync[k]   <= r_cs_sync[k-1];
                    end
                end
            end
            assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
            assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
            assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
        end
    endgenerate

    logic [1:0]        r_state;
    logic              r_sclk_prev;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-2:0] r_rx_shift;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] r_tx_buf;
    logic              r_tx_full;
    logic              r_frame_done;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_tx_underrun;
    logic              r_busy;

    logic              w_rise, w_fall, w_take;
    logic [DATA_W-1:0] w_rx_next;

    assign w_rise    = w_sclk & ~r_sclk_prev;
    assign w_fall    = ~w_sclk & r_sclk_prev;
    assign w_take    = (r_state == ST_LOAD) && !w_cs_n;
    assign w_rx_next = {r_rx_shift, w_mosi};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sclk_prev <= 1'b0;
        else          r_sclk_prev <= w_sclk;
    end

    // A LOAD sees the buffer's old state, so a same-cycle tx_load waits for the next frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_full <= 1'b0;
            r_tx_buf  <= '0;
        end else if (w_take && r_tx_full) begin
            r_tx_full <= 1'b0;
        end else if (i_tx_load && !r_tx_full) begin
            r_tx_full <= 1'b1;
            r_tx_buf  <= i_tx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_frame_done  <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx_shift   <= '0;
                    r_bit_cnt    <= '0;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                    if (!w_cs_n) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_cs_n) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_tx_shift    <= r_tx_full ? r_tx_buf : '0;
                        r_tx_underrun <= !r_tx_full;
                        r_bit_cnt     <= '0;
                        r_busy        <= 1'b0;
                        r_frame_done  <= 1'b0;
                        r_state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_n) begin
                        r_state      <= ST_IDLE;
                        r_tx_shift   <= '0;
                        r_bit_cnt    <= '0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b0;
                    end else begin
                        // frame_done gates further rises so bit_cnt stops at DATA_W
                        if (w_rise && !r_frame_done) begin
                            r_rx_shift <= w_rx_next[DATA_W-2:0];
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                                r_rx_data    <= w_rx_next;
                                r_rx_valid   <= 1'b1;
                                r_frame_done <= 1'b1;
                                r_busy       <= 1'b0;
                            end else begin
                                r_busy <= 1'b1;
                            end
                        end
                        if (w_fall) begin
                            if (r_frame_done) begin
                                r_frame_done <= 1'b0;
                                r_state      <= ST_LOAD;
                            end else begin
                                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_miso        = r_tx_shift[DATA_W-1];
    assign o_tx_ready    = !r_tx_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_tx_underrun;
    assign o_busy        = r_busy;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one same-domain and one 2-stage-synchronised instance share
// a bench-driven mode-0 master; a frame-level model predicts rx bytes, miso bits and underruns.
module tb_spi_slave;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n, cs_n, sclk, mosi, tx_load;
    logic [7:0] tx_data;
    logic [1:0] miso, tx_ready, rx_valid, underrun, busy;
    logic [7:0] rx_data [2];

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cs_n(cs_n), .i_sclk(sclk), .i_mosi(mosi),
        .o_miso(miso[0]), .i_tx_data(tx_data), .i_tx_load(tx_load), .o_tx_ready(tx_ready[0]),
        .o_rx_data(rx_data[0]), .o_rx_valid(rx_valid[0]), .o_tx_underrun(underrun[0]), .o_busy(busy[0]));

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cs_n(cs_n), .i_sclk(sclk), .i_mosi(mosi),
        .o_miso(miso[1]), .i_tx_data(tx_data), .i_tx_load(tx_load), .o_tx_ready(tx_ready[1]),
        .o_rx_data(rx_data[1]), .o_rx_valid(rx_valid[1]), .o_tx_underrun(underrun[1]), .o_busy(busy[1]));

    int checks = 0, passes = 0;
    int rxcnt [2] = '{0, 0};
    int ucnt  [2] = '{0, 0};
    int rx_exp_cnt = 0, und_exp = 0;
    logic [7:0] exp_rx = 8'h00;
    logic       full   = 1'b0;
    logic [7:0] buf_v  = 8'h00;
    logic [7:0] em     = 8'h00;

    task automatic chk8(string name, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask
    task automatic chk1(string name, logic act, logic req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0b want %0b", name, act, req);
    endtask
    task automatic chki(string name, int act, int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d want %0d", name, act, req);
    endtask

    // every rx strobe must carry the byte the master is currently sending
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (rx_valid[d]) begin
                    rxcnt[d]++;
                    chk8($sformatf("rx_data_dut%0d", d), rx_data[d], exp_rx);
                end
                if (underrun[d]) ucnt[d]++;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // a frame start consumes the buffer if full, otherwise sends zeros and flags underrun
    task automatic model_load();
        em = full ? buf_v : 8'h00;
        if (!full) und_exp++;
        full = 1'b0;
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        model_load();
        tick(6);
    endtask

    task automatic load(logic [7:0] v);
        tx_data = v; tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0; full = 1'b1; buf_v = v;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk1($sformatf("tx_ready_after_load%0d", d), tx_ready[d], 1'b0);
    endtask

    task automatic chk_reset();
        for (int d = 0; d < 2; d++) begin
            chk1($sformatf("rst_miso%0d", d), miso[d], 1'b0);
            chk8($sformatf("rst_rx_data%0d", d), rx_data[d], 8'h00);
            chk1($sformatf("rst_rx_valid%0d", d), rx_valid[d], 1'b0);
            chk1($sformatf("rst_underrun%0d", d), underrun[d], 1'b0);
            chk1($sformatf("rst_busy%0d", d), busy[d], 1'b0);
            chk1($sformatf("rst_tx_ready%0d", d), tx_ready[d], 1'b1);
        end
    endtask

    task automatic frame(logic [7:0] mo, int nbits, logic do_load, logic [7:0] ld);
        exp_rx = mo;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            if (i == 1 && do_load) begin
                tx_data = ld; tx_load = 1'b1;
                tick(1);
                tx_load = 1'b0; full = 1'b1; buf_v = ld;
                tick(H - 2);
            end else begin
                tick(H - 1);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) chk1($sformatf("miso_setup%0d_bit%0d", d, i), miso[d], em[7-i]);
            tick(1); sclk = 1'b1;
            tick(H - 1);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk1($sformatf("miso_hold%0d_bit%0d", d, i), miso[d], em[7-i]);
                chk1($sformatf("busy%0d_bit%0d", d, i), busy[d], 1'(i < 7));
            end
            tick(1); sclk = 1'b0;
        end
        if (nbits == 8) begin
            rx_exp_cnt++;
            tick(6);
            model_load();
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chki($sformatf("rx_count%0d", d), rxcnt[d], rx_exp_cnt);
                chki($sformatf("underrun_count%0d", d), ucnt[d], und_exp);
                chk8($sformatf("rx_held%0d", d), rx_data[d], mo);
                chk1($sformatf("tx_ready%0d", d), tx_ready[d], !full);
                chk1($sformatf("busy_end%0d", d), busy[d], 1'b0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b0; sclk = 1'b0; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
        tick(3);
        @(negedge clk);
        chk_reset();
        tick(1);
        rst_n = 1'b1;
        model_load();
        tick(6);

        // unframed: out-of-reset frame underruns, then buffered replies follow back-to-back
        frame(8'($urandom), 8, 1'b1, 8'h3C);
        chk8("model_em_3c", em, 8'h3C);
        frame(8'hA5, 8, 1'b1, 8'h5A);
        frame(8'h01, 8, 1'b1, 8'hC3);
        frame(8'h80, 8, 1'b0, 8'h00);
        chk8("model_em_zero", em, 8'h00);
        chki("model_und_2", und_exp, 2);
        frame(8'($urandom), 8, 1'b0, 8'h00);
        cs_n = 1'b1;
        tick(6);
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk1($sformatf("idle_miso%0d", d), miso[d], 1'b0);

        // randomized frames, optionally re-framed with cs_n and optionally reloaded
        start_frame();
        for (int n = 0; n < 10; n++) begin
            if (1'($urandom_range(0, 1))) begin
                cs_n = 1'b1;
                tick(int'($urandom_range(3, 6)));
                start_frame();
            end
            frame(8'($urandom), 8, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // framed byte with a preloaded reply
        cs_n = 1'b1;
        tick(4);
        load(8'h81);
        start_frame();
        frame(8'hF0, 8, 1'b0, 8'h00);

        // abort after 4 rises
        cs_n = 1'b1;
        tick(4);
        start_frame();
        frame(8'($urandom), 4, 1'b0, 8'h00);
        cs_n = 1'b1;
        tick(6);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk1($sformatf("abort_busy%0d", d), busy[d], 1'b0);
            chki($sformatf("abort_rx_count%0d", d), rxcnt[d], rx_exp_cnt);
            chk1($sformatf("abort_miso%0d", d), miso[d], 1'b0);
        end
        start_frame();
        frame(8'h69, 8, 1'b0, 8'h00);

        // reset mid-frame after 3 bits with the buffer refilled
        cs_n = 1'b1;
        tick(4);
        start_frame();
        frame(8'($urandom), 3, 1'b1, 8'hAA);
        rst_n = 1'b0; cs_n = 1'b1;
        full = 1'b0;
        @(negedge clk);
        chk_reset();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        load(8'h5A);
        start_frame();
        chk8("model_em_5a", em, 8'h5A);
        frame(8'h96, 8, 1'b0, 8'h00);

        cs_n = 1'b1;
        tick(4);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
